// File: rtl/apb_ctrl_pkg.sv
// Shared types and widths for the two-requester APB master.
package apb_ctrl_pkg;

    localparam int unsigned ApbAddrWidth = 32;
    localparam int unsigned ApbDataWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } apb_state_e;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and a single slave.
interface apb_arb_master_if;
    import apb_ctrl_pkg::*;

    logic [ApbAddrWidth-1:0] PADDR;
    logic [ApbDataWidth-1:0] PWDATA;
    logic [ApbDataWidth-1:0] PRDATA;
    logic                    PWRITE;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_arb_master_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when a grant is taken.
module rr_arbiter2
    import apb_ctrl_pkg::*;
(
    input  logic     PCLK,
    input  logic     PRESET,
    input  logic [1:0] req_i,
    input  logic     update_i,
    output req_id_t  gnt_o,
    output logic     any_o
);

    req_id_t last_q;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        any_o = |req_i;
        gnt_o = (req_i == 2'b11) ? ~last_q : req_i[1];
    end

    // Reset points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_arb_master
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,

    input  logic                    req0_valid,
    input  logic                    req0_write,
    input  logic [ApbAddrWidth-1:0] req0_addr,
    input  logic [ApbDataWidth-1:0] req0_wdata,
    output logic                    req0_done,
    output logic [ApbDataWidth-1:0] req0_rdata,
    output logic                    req0_err,

    input  logic                    req1_valid,
    input  logic                    req1_write,
    input  logic [ApbAddrWidth-1:0] req1_addr,
    input  logic [ApbDataWidth-1:0] req1_wdata,
    output logic                    req1_done,
    output logic [ApbDataWidth-1:0] req1_rdata,
    output logic                    req1_err,

    apb_arb_master_if.master        apb
);

    if (TIMEOUT_CYCLES == 0) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_e              state_q;
    req_id_t                 gnt_q;
    req_id_t                 arb_gnt;
    logic                    arb_any;
    logic [ApbAddrWidth-1:0] addr_q;
    logic [ApbDataWidth-1:0] wdata_q;
    logic                    write_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [1:0]              done_q;
    logic [ApbDataWidth-1:0] rdata_q [2];

    logic                    pick_write;
    logic [ApbAddrWidth-1:0] pick_addr;
    logic [ApbDataWidth-1:0] pick_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] cnt_q;
    logic [1:0]          err_q;
`endif

    rr_arbiter2 u_arb (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req_i    ({req1_valid, req0_valid}),
        .update_i (state_q == StIdle && arb_any),
        .gnt_o    (arb_gnt),
        .any_o    (arb_any)
    );

    always_comb begin
        pick_write = arb_gnt ? req1_write : req0_write;
        pick_addr  = arb_gnt ? req1_addr  : req0_addr;
        pick_wdata = arb_gnt ? req1_wdata : req0_wdata;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            done_q     <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= '0;
`endif
        end else begin
            // Completion outputs are single-cycle pulses.
            done_q     <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
`ifdef APB_TIMEOUT_EN
            err_q      <= '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                        write_q <= pick_write;
                        psel_q  <= 1'b1;
                        state_q <= StSetup;
`ifdef APB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (apb.PREADY) begin
                        psel_q          <= 1'b0;
                        penable_q       <= 1'b0;
                        done_q[gnt_q]   <= 1'b1;
                        rdata_q[gnt_q]  <= write_q ? '0 : apb.PRDATA;
                        state_q         <= StDone;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1)) begin
                        psel_q          <= 1'b0;
                        penable_q       <= 1'b0;
                        done_q[gnt_q]   <= 1'b1;
                        err_q[gnt_q]    <= 1'b1;
                        state_q         <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign apb.PADDR   = addr_q;
    assign apb.PWDATA  = wdata_q;
    assign apb.PWRITE  = write_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;

    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];

`ifdef APB_TIMEOUT_EN
    assign req0_err = err_q[0];
    assign req1_err = err_q[1];
`else
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
`endif

endmodule
